iter_div_unit: RTL
==================

// Module: iter_div_unit
// PURPOSE
//  Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
//  Sits in EX next to the Booth multiplier. It stalls the pipeline while iterating and
//  pulses a register-file write strobe when the result is ready.
// PARAMETERS
//  XLEN  32  operand/result width; >=2, else $error at elaboration
// PORTS
//  i_clk       in   1     clock
//  i_rst       in   1     reset: synchronous, active-high
//  i_en        in   1     divide instruction present in EX (held high while stalled)
//  i_op        in   2     div_op_t: DIV=0, DIVU=1, REM=2, REMU=3
//  i_dividend  in   XLEN  rs1
//  i_divisor   in   XLEN  rs2
//  o_result    out  XLEN  quotient/remainder; valid only while o_we=1, else 0
//  o_stall     out  1     hold the pipeline
//  o_we        out  1     1-cycle write strobe
//  o_busy      out  1     state != IDLE
// BEHAVIOUR
//  - States: IDLE, CALC, DONE. Counter r_cnt [$clog2(XLEN)-1:0].
//  - Reset values: state=IDLE, r_cnt=0, and all outputs 0.
//  - IDLE:
//    - With i_en=1: latch op, sign flags, |dividend|, |divisor| (abs only for DIV/REM), r_cnt=0.
//    - Go to CALC. o_stall=1 combinationally in this cycle.
//  - CALC, one step per cycle:
//    - rem' = {rem,quo[MSB]} - divisor.
//    - If non-negative: keep it and shift in 1. Otherwise restore and shift in 0.
//    - r_cnt++ each step. At r_cnt==XLEN-1 go to DONE. o_stall=1 throughout.
//  - DONE:
//    - o_stall=0 and o_we=1 for exactly one cycle, then go to IDLE.
//    - i_en is ignored in DONE; that instruction retires this cycle.
//  - Latency: o_stall is high for XLEN+1 cycles (accept + XLEN steps). o_we is high in cycle XLEN+1.
//  - Sign fixup (combinational in DONE):
//    - Quotient is negated if the operand signs differ.
//    - Remainder takes the dividend's sign. Magnitudes are unsigned XLEN bits.
//  - Special results (RISC-V spec), produced in DONE regardless of the iteration:
//    - divisor==0: quotient = all ones; remainder = dividend.
//    - Signed overflow (-2^(XLEN-1) / -1): quotient = -2^(XLEN-1); remainder = 0.
//  - i_op, i_dividend and i_divisor are sampled only at accept; later changes are ignored.
//  - i_rst in any state aborts: state goes to IDLE next cycle and no o_we is issued.
//  - Back-to-back: a new i_en is accepted in the cycle after DONE (IDLE).
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined:
//   - In IDLE, if i_en=1 and (divisor==0, signed overflow, or divisor==1):
//     skip CALC and go straight to DONE.
//   - Latency 1: o_stall=1 in the accept cycle only; o_we in the next cycle.
//   - Results are identical to the full path.
//  DIV_EARLY_OUT_EN undefined: every operation takes the full XLEN+1 stall cycles.
// STRUCTURE
//  - Shared package `types`: div_op_t enum; div_state_t {IDLE, CALC, DONE}.
//  - Sub-module iter_div_step: combinational single restoring step.
//    (rem_in, quo_in, divisor) -> (rem_out, quo_out).
//  - Top holds FSM, counter, operand registers and fixup/result mux.
// TESTING
//  1 DIVU 100/7: o_stall=1 for 33 cycles; o_we at cycle 33, result 14. REMU 100/7 -> 2.
//  2 DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1).
//    REM 7/-2 -> 1. DIV -8/-2 -> 4.
//  3 DIV x/0, x=0x12345678 -> 0xFFFFFFFF; REMU x/0 -> 0x12345678.
//    With DIV_EARLY_OUT_EN: o_we in cycle 1.
//  4 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
//    Early-out latency checked when the macro is defined.
//  5 i_rst at CALC step 10 -> next cycle o_busy=0, o_stall=0, no o_we.
//    A following DIVU 9/3 -> 3 with normal latency.
//  6 Two back-to-back DIVU (50/5, 81/9):
//    one o_we each (10, 9), one IDLE cycle between, no double accept in DONE.

Source files
------------

// File: rtl/types.sv
// rtl/types.sv - shared enums for the iterative divider (op codes and FSM states)
package types;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic logic is_signed_op(input div_op_t op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem_op(input div_op_t op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/iter_div_step.sv
// rtl/iter_div_step.sv - one combinational radix-2 restoring division step
module iter_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  assign shifted = {rem_in, quo_in[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor};

  // diff[XLEN] set means the trial subtraction went negative: restore
  always_comb begin
    rem_out = shifted[XLEN-1:0];
    quo_out = {quo_in[XLEN-2:0], 1'b0};
    if (!diff[XLEN]) begin
      rem_out = diff[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/iter_div_unit.sv
// rtl/iter_div_unit.sv - multi-cycle RV32M DIV/DIVU/REM/REMU unit with pipeline stall
// Optional DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and divide-by-one skip the iteration.
module iter_div_unit
  import types::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_result,
  output logic            o_stall,
  output logic            o_we,
  output logic            o_busy
);

  if (XLEN < 2) begin : g_xlen_check
    $error("iter_div_unit: XLEN must be >= 2");
  end

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

  div_state_t      r_state, nxt_state;
  logic [CNT_W-1:0] r_cnt;
  div_op_t         r_op;
  logic            r_neg_q, r_neg_r, r_div0, r_ovf;
  logic [XLEN-1:0] r_rem, r_quo, r_dsr, r_dvd;

  div_op_t         op_in;
  logic            in_signed, a_neg, b_neg, in_div0, in_ovf, early;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN-1:0] s_rem, s_quo;
  logic [XLEN-1:0] q_fix, r_fix;

  assign op_in     = div_op_t'(i_op);
  assign in_signed = is_signed_op(op_in);
  assign a_neg     = in_signed & i_dividend[XLEN-1];
  assign b_neg     = in_signed & i_divisor[XLEN-1];
  assign abs_a     = a_neg ? -i_dividend : i_dividend;
  assign abs_b     = b_neg ? -i_divisor : i_divisor;
  assign in_div0   = (i_divisor == '0);
  assign in_ovf    = in_signed && (i_dividend == MIN_NEG) && (i_divisor == '1);

`ifdef DIV_EARLY_OUT_EN
  // quotient register already holds |dividend| and remainder 0, which is the divide-by-one answer
  assign early = in_div0 | in_ovf | (i_divisor == ONE);
`else
  assign early = 1'b0;
`endif

  iter_div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (r_rem),
    .quo_in  (r_quo),
    .divisor (r_dsr),
    .rem_out (s_rem),
    .quo_out (s_quo)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= DIV;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_ovf   <= 1'b0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dsr   <= '0;
      r_dvd   <= '0;
    end else begin
      r_state <= nxt_state;
      if (r_state == IDLE && i_en) begin
        r_cnt   <= '0;
        r_op    <= op_in;
        r_neg_q <= a_neg ^ b_neg;
        r_neg_r <= a_neg;
        r_div0  <= in_div0;
        r_ovf   <= in_ovf;
        r_rem   <= '0;
        r_quo   <= abs_a;
        r_dsr   <= abs_b;
        r_dvd   <= i_dividend;
      end else if (r_state == CALC) begin
        r_rem <= s_rem;
        r_quo <= s_quo;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    nxt_state = r_state;
    o_stall   = 1'b0;
    o_we      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_en) begin
          o_stall   = 1'b1;
          nxt_state = early ? DONE : CALC;
        end
      end
      CALC: begin
        o_stall = 1'b1;
        if (r_cnt == LAST_STEP) nxt_state = DONE;
      end
      DONE: begin
        o_we      = 1'b1;
        nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
    // a reset cycle must never stall the pipe or retire a result
    if (i_rst) begin
      o_stall = 1'b0;
      o_we    = 1'b0;
    end
  end

  always_comb begin
    q_fix = r_neg_q ? -r_quo : r_quo;
    r_fix = r_neg_r ? -r_rem : r_rem;
    if (r_div0) begin
      q_fix = '1;
      r_fix = r_dvd;
    end else if (r_ovf) begin
      q_fix = MIN_NEG;
      r_fix = '0;
    end
  end

  assign o_result = o_we ? (is_rem_op(r_op) ? r_fix : q_fix) : '0;
  assign o_busy   = (r_state != IDLE);

endmodule
